// File: rtl/hs_pkg.sv
// Shared constants and width helpers for the handshake FIFO bridge.
package hs_pkg;

    localparam int unsigned HS_WIDTH = 9;
    localparam int unsigned HS_DEPTH = 256;

    // Pointer carries one extra wrap bit above the address bits.
    function automatic int unsigned hs_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned hs_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module hs_fifo_mem #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hs_fifo_bridge.sv
// Valid/ready FWFT buffer with flush, almost-full flag, occupancy and
// completed-transfer counter.
module hs_fifo_bridge
    import hs_pkg::*;
#(
    parameter int unsigned WIDTH    = HS_WIDTH,
    parameter int unsigned DEPTH    = HS_DEPTH,
    parameter int unsigned AFULL_TH = DEPTH - 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        s_rst_n,
    input  logic                        flush,
    input  logic                        in_vaild,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_vaild,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [hs_cnt_w(DEPTH)-1:0]  count,
    output logic                        almost_full,
    output logic [CNT_W-1:0]            xfer_cnt
);

    localparam int unsigned PW = hs_ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;
    localparam int unsigned CW = hs_cnt_w(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             afull_q, afull_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic             wr_fire, rd_fire;

    // in_ready depends only on registered state and flush, never on out_ready.
    assign in_ready    = (count_q != CW'(DEPTH)) && !flush;
    assign out_vaild   = (count_q != '0);
    assign count       = count_q;
    assign almost_full = afull_q;
    assign xfer_cnt    = xfer_q;

    always_comb begin
        wr_fire  = in_vaild && in_ready;
        rd_fire  = out_vaild && out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        xfer_d   = xfer_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            xfer_d   = xfer_q + CNT_W'(1);
        end

        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flush wins over pointer/count updates but a read in the same cycle
        // still counts as a completed transfer.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        afull_d = (count_d >= CW'(AFULL_TH));
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
            xfer_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            xfer_q   <= xfer_d;
        end
    end

    hs_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_hs_fifo_bridge.sv
// Directed self-checking bench for hs_fifo_bridge at DEPTH=4, WIDTH=9.
module tb_hs_fifo_bridge;

    localparam int unsigned WIDTH = 9;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             s_rst_n;
    logic             flush;
    logic             in_vaild;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_vaild;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [2:0]       count;
    logic             almost_full;
    logic [CNT_W-1:0] xfer_cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    hs_fifo_bridge #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AFULL_TH (2),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .s_rst_n     (s_rst_n),
        .flush       (flush),
        .in_vaild    (in_vaild),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_vaild   (out_vaild),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full),
        .xfer_cnt    (xfer_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        s_rst_n   = 1'b0;
        flush     = 1'b0;
        in_vaild  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        repeat (2) step();
        check_eq("rst_ovalid", 32'(out_vaild), 32'd0);
        check_eq("rst_iready", 32'(in_ready), 32'd1);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_afull", 32'(almost_full), 32'd0);
        check_eq("rst_xfer", 32'(xfer_cnt), 32'd0);
        s_rst_n = 1'b1;
        step();

        // Fill three beats with the consumer stalled.
        for (int i = 1; i <= 3; i++) begin
            in_vaild = 1'b1;
            in_data  = WIDTH'(i);
            step();
            if (i == 1) begin
                check_eq("lat1_ovalid", 32'(out_vaild), 32'd1);
                check_eq("lat1_odata", 32'(out_data), 32'h001);
            end
        end
        in_vaild = 1'b0;
        check_eq("fill3_count", 32'(count), 32'd3);
        check_eq("fill3_afull", 32'(almost_full), 32'd1);
        check_eq("fill3_odata", 32'(out_data), 32'h001);
        check_eq("fill3_iready", 32'(in_ready), 32'd1);

        in_vaild = 1'b1;
        in_data  = 9'h004;
        step();
        check_eq("full_count", 32'(count), 32'd4);
        check_eq("full_iready", 32'(in_ready), 32'd0);
        in_data = 9'h005;
        step();
        check_eq("full_hold_count", 32'(count), 32'd4);
        check_eq("full_hold_odata", 32'(out_data), 32'h001);

        // Read at full: no bypass, 0x005 lands on the following edge.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("rd_full_count", 32'(count), 32'd3);
        check_eq("rd_full_iready", 32'(in_ready), 32'd1);
        check_eq("rd_full_odata", 32'(out_data), 32'h002);
        check_eq("rd_full_xfer", 32'(xfer_cnt), 32'd1);
        step();
        in_vaild = 1'b0;
        check_eq("late_wr_count", 32'(count), 32'd4);
        check_eq("late_wr_iready", 32'(in_ready), 32'd0);

        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check_eq("drain_odata", 32'(out_data), 32'(i));
            step();
        end
        check_eq("drain_ovalid", 32'(out_vaild), 32'd0);
        check_eq("drain_xfer", 32'(xfer_cnt), 32'd5);
        check_eq("drain_afull", 32'(almost_full), 32'd0);

        // Continuous stream across several pointer wraps.
        in_vaild = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = WIDTH'(9'h010 + i);
            step();
            check_eq("strm_odata", 32'(out_data), 32'h010 + 32'(i));
            check_eq("strm_count", 32'(count), 32'd1);
        end
        in_vaild = 1'b0;
        step();
        check_eq("strm_ovalid", 32'(out_vaild), 32'd0);
        check_eq("strm_xfer", 32'(xfer_cnt), 32'd25);

        // Flush with a concurrent write and read.
        out_ready = 1'b0;
        in_vaild  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = WIDTH'(9'h030 + i);
            step();
        end
        check_eq("pre_fl_count", 32'(count), 32'd3);
        flush     = 1'b1;
        in_data   = 9'h033;
        out_ready = 1'b1;
        #1;
        check_eq("fl_iready", 32'(in_ready), 32'd0);
        step();
        flush     = 1'b0;
        in_vaild  = 1'b0;
        out_ready = 1'b0;
        check_eq("fl_count", 32'(count), 32'd0);
        check_eq("fl_ovalid", 32'(out_vaild), 32'd0);
        check_eq("fl_afull", 32'(almost_full), 32'd0);
        check_eq("fl_xfer", 32'(xfer_cnt), 32'd26);
        in_vaild = 1'b1;
        in_data  = 9'h040;
        step();
        in_vaild = 1'b0;
        check_eq("post_fl_count", 32'(count), 32'd1);
        check_eq("post_fl_odata", 32'(out_data), 32'h040);

        // Asynchronous reset mid-stream.
        in_vaild  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = WIDTH'(9'h050 + i);
            step();
        end
        #2;
        s_rst_n = 1'b0;
        #1;
        check_eq("arst_ovalid", 32'(out_vaild), 32'd0);
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_xfer", 32'(xfer_cnt), 32'd0);
        check_eq("arst_iready", 32'(in_ready), 32'd1);
        in_vaild  = 1'b0;
        out_ready = 1'b0;
        step();
        s_rst_n = 1'b1;
        step();

        in_vaild  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = WIDTH'(9'h060 + i);
            step();
            check_eq("resume_odata", 32'(out_data), 32'h060 + 32'(i));
            check_eq("resume_count", 32'(count), 32'd1);
        end
        in_vaild = 1'b0;
        step();
        check_eq("resume_xfer", 32'(xfer_cnt), 32'd3);
        check_eq("resume_ovalid", 32'(out_vaild), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_fifo_bridge.md
Name: hs_fifo_bridge

Overview:
Parametrised valid/ready buffer placed between a handshake source and destination. It decouples producer and consumer with DEPTH entries of WIDTH-bit storage and first-word-fall-through output. It adds flush, an almost-full flag, an occupancy count and a transfer counter. It succeeds the fixed point-to-point source/destination handshake and is dropped in wherever back-pressure must be absorbed.

Parameters:
WIDTH, 9, data bits per beat
DEPTH, 256, entry count; power of two, >=2
AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH
CNT_W, 16, width of xfer_cnt

Ports:
clk  input  1  single clock, rising edge
s_rst_n  input  1  reset, asynchronous assert, active-low
flush  input  1  synchronous clear of contents
in_vaild  input  1  upstream beat valid
in_data  input  WIDTH  upstream beat data
in_ready  output  1  bridge can accept a beat
out_vaild  output  1  downstream beat valid
out_data  output  WIDTH  downstream beat data
out_ready  input  1  downstream accepts the beat
count  output  $clog2(DEPTH+1)  current occupancy
almost_full  output  1  count >= AFULL_TH
xfer_cnt  output  CNT_W  completed output transfers, wraps at 2^CNT_W

Behaviour:
- Reset: s_rst_n low, asynchronous. Pointers, count and xfer_cnt go to 0. out_vaild=0, in_ready=1, almost_full=0. Storage is not reset. out_data is don't-care while out_vaild=0.
- Write fires when in_vaild && in_ready. Read fires when out_vaild && out_ready. Both are evaluated on the same edge.
- in_ready = (count != DEPTH) && !flush. It is combinational from registered state and flush only, with no path from out_ready. At full with out_ready=1 there is no bypass write; in_ready rises the cycle after the read.
- out_vaild = (count != 0). out_data = entry at the read pointer (FWFT).
- Latency: a beat written into an empty buffer is visible on out_vaild/out_data at the next edge. Minimum latency is 1 cycle.
- Once out_vaild=1 and out_ready=0, out_data and out_vaild must hold until the read fires. A later write must not disturb them.
- Simultaneous write and read at 0<count<DEPTH: count is unchanged and both pointers advance.
- Write-only: count+1. Read-only: count-1.
- Pointers are $clog2(DEPTH)+1 bits with an extra wrap bit. Full when the low bits are equal and the wrap bits differ. Empty when the pointers are equal. Wrap-around at DEPTH-1 to 0 is seamless.
- flush=1 at an edge sets both pointers and count to 0, so out_vaild=0 next cycle. It has priority over any write or read that edge, and in_ready is 0 during flush. xfer_cnt is not cleared by flush, but a read that fires in the flush cycle is still counted.
- xfer_cnt increments by 1 on each fired read and wraps modulo 2^CNT_W.
- almost_full is registered, updated with count. It deasserts on the edge count drops below AFULL_TH.
- Reset mid-transfer: all in-flight beats are lost and the outputs take their reset values immediately (asynchronous).
- No states beyond the pointer/count registers; the control is a counter-based FIFO controller.

Decomposition:
- Shared package hs_pkg: the pointer-width and count-width helper functions ($clog2-based), plus the default WIDTH=9 / DEPTH=256 constants.
- One sub-module, hs_fifo_mem: a DEPTH x WIDTH register array with synchronous write and asynchronous read at the read pointer.
- The bridge holds the pointers, count, flags and xfer_cnt.

Test Plan:
- DEPTH=4, WIDTH=9. Reset, then push 0x001..0x003 with out_ready=0 -> count=3, almost_full=1 (AFULL_TH=2), out_data=0x001 held stable, in_ready=1.
- Push a 4th beat 0x004 with out_ready=0 -> count=4, in_ready=0. A 5th beat 0x005 presented is not accepted.
- At full, raise out_ready for one cycle -> 0x001 is read, count=3, in_ready=1 next cycle. 0x005 is accepted the following edge, not in the same cycle.
- Stream 20 beats 0x010..0x023 with in_vaild=1 and out_ready=1 continuously -> output order is preserved across pointer wrap, count stays at 1 after the first beat, and xfer_cnt reaches 20 (plus earlier reads).
- With count=3, assert flush together with in_vaild=1 and out_ready=1 -> next cycle count=0, out_vaild=0, the write is dropped, and xfer_cnt has incremented by 1.
- Drop s_rst_n asynchronously mid-stream (between edges) -> out_vaild=0, count=0, xfer_cnt=0 immediately, without waiting for a clock edge. Traffic resumes correctly after release.
